// File: rtl/detdes_pkg.sv
// Shared parameters and state encoding for the frame unloader.
package detdes_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REGDEPTH   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/regs_unload_3.sv
// Captures a three-word frame in one cycle and unloads it word by word
// (din03, din02, din01) over a valid/ready stream with a registered output.
module regs_unload_3 #(
    parameter int DATA_WIDTH = detdes_pkg::DATA_WIDTH,
    parameter int REGDEPTH   = detdes_pkg::REGDEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din03,
    input  logic [DATA_WIDTH-1:0] din02,
    input  logic [DATA_WIDTH-1:0] din01,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last
);
    import detdes_pkg::*;

    state_e                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [DATA_WIDTH-1:0] frame_q [REGDEPTH];
    logic [DATA_WIDTH-1:0] frame_d [REGDEPTH];
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  dout_last_q, dout_last_d;
    logic                  accept;
    logic                  consume;

    // Reload is allowed in SEND only while the final word leaves this cycle.
    assign in_ready = (state_q == IDLE) || (dout_valid_q && dout_last_q && dout_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = dout_valid_q && dout_ready;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_d      = frame_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        if (accept) begin
            state_d      = SEND;
            idx_d        = 2'd0;
            frame_d[0]   = din03;
            frame_d[1]   = din02;
            frame_d[2]   = din01;
            dout_d       = din03;
            dout_valid_d = 1'b1;
            dout_last_d  = 1'b0;
        end else if (consume) begin
            case (idx_q)
                2'd0: begin
                    idx_d       = 2'd1;
                    dout_d      = frame_q[1];
                    dout_last_d = 1'b0;
                end
                2'd1: begin
                    idx_d       = 2'd2;
                    dout_d      = frame_q[2];
                    dout_last_d = 1'b1;
                end
                default: begin
                    // Last word gone: dout keeps its value, only valid drops.
                    state_d      = IDLE;
                    idx_d        = 2'd0;
                    dout_valid_d = 1'b0;
                    dout_last_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            for (int i = 0; i < REGDEPTH; i++) begin
                frame_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_q      <= frame_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;

endmodule

// File: tb/tb_regs_unload_3.sv
// Bench for regs_unload_3: directed scenarios plus randomized traffic against a
// queue-based model of the words still owed to the downstream side.
module tb_regs_unload_3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din03, din02, din01;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;

    int passed = 0;
    int total  = 0;

    // Model: words of the current frame not yet taken; front is what dout shows.
    logic [31:0] mq[$];
    logic [31:0] m_shown;

    regs_unload_3 dut (
        .clk        (clk),
        .rst        (rst),
        .din03      (din03),
        .din02      (din02),
        .din01      (din01),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last)
    );

    always #5 clk = ~clk;

    function automatic logic m_ready();
        return (mq.size() == 0) || (mq.size() == 1 && dout_ready);
    endfunction

    task automatic tick();
        logic acc;
        acc = in_valid && m_ready() && !rst;
        if (!rst && mq.size() > 0 && dout_ready) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(din03);
            mq.push_back(din02);
            mq.push_back(din01);
        end
        if (mq.size() > 0) m_shown = mq[0];
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; dout_ready = 1'b0;
        din03 = '0; din02 = '0; din01 = '0;
        mq.delete(); m_shown = '0;
        #1;
        total++;
        if (dout_valid !== 1'b0 || dout !== 32'h0 || dout_last !== 1'b0) begin
            $display("FAIL reset_init: valid=%b dout=%h last=%b, want 0/0/0",
                     dout_valid, dout, dout_last);
        end else passed++;
        @(posedge clk); #2; rst = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
        else passed++;
        // Mid-frame reset after one word has left.
        din03 = 32'h53; din02 = 32'h52; din01 = 32'h51; in_valid = 1'b1; dout_ready = 1'b1;
        #1; tick();
        in_valid = 1'b0;
        #1; tick();
        total++;
        if (dout !== 32'h52 || dout_valid !== 1'b1)
            $display("FAIL reset_pre: dout=%h valid=%b want 52/1", dout, dout_valid);
        else passed++;
        rst = 1'b1;
        #1;
        mq.delete(); m_shown = '0;
        total++;
        if (dout_valid !== 1'b0 || dout !== 32'h0 || dout_last !== 1'b0)
            $display("FAIL reset_async: valid=%b dout=%h last=%b want 0/0/0",
                     dout_valid, dout, dout_last);
        else passed++;
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready2: in_ready=%b want 1", in_ready);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (dout_valid !== 1'b0 || dout !== 32'h0)
                $display("FAIL reset_discard: cycle %0d valid=%b dout=%h want 0/0",
                         i, dout_valid, dout);
            else passed++;
            tick();
        end
    endtask

    task automatic test_single();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'hA3; exp_w[1] = 32'hA2; exp_w[2] = 32'hA1;
        din03 = 32'hA3; din02 = 32'hA2; din01 = 32'hA1; in_valid = 1'b1; dout_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL single_ready: in_ready=%b want 1", in_ready);
        else passed++;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (dout_valid !== 1'b1 || dout !== exp_w[k] || dout_last !== (k == 2))
                $display("FAIL single_word%0d: valid=%b dout=%h last=%b want 1/%h/%b",
                         k, dout_valid, dout, dout_last, exp_w[k], (k == 2));
            else passed++;
            tick();
        end
        total++;
        if (dout_valid !== 1'b0 || dout !== 32'hA1 || dout_last !== 1'b0)
            $display("FAIL single_idle: valid=%b dout=%h last=%b want 0/a1/0",
                     dout_valid, dout, dout_last);
        else passed++;
    endtask

    task automatic test_backpressure();
        din03 = 32'hA3; din02 = 32'hA2; din01 = 32'hA1; in_valid = 1'b1; dout_ready = 1'b1;
        #1; tick();
        in_valid = 1'b0;
        #1; tick();
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (dout !== 32'hA2 || dout_valid !== 1'b1 || in_ready !== 1'b0 || dout_last !== 1'b0)
                $display("FAIL bp_hold%0d: dout=%h valid=%b in_ready=%b last=%b want a2/1/0/0",
                         i, dout, dout_valid, in_ready, dout_last);
            else passed++;
            tick();
        end
        dout_ready = 1'b1;
        #1;
        total++;
        if (dout !== 32'hA2) $display("FAIL bp_release: dout=%h want a2", dout);
        else passed++;
        tick();
        total++;
        if (dout !== 32'hA1 || dout_last !== 1'b1)
            $display("FAIL bp_last: dout=%h last=%b want a1/1", dout, dout_last);
        else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [6];
        exp_w[0] = 32'h13; exp_w[1] = 32'h12; exp_w[2] = 32'h11;
        exp_w[3] = 32'h23; exp_w[4] = 32'h22; exp_w[5] = 32'h21;
        din03 = 32'h13; din02 = 32'h12; din01 = 32'h11; in_valid = 1'b1; dout_ready = 1'b1;
        #1; tick();
        din03 = 32'h23; din02 = 32'h22; din01 = 32'h21;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if (dout_valid !== 1'b1 || dout !== exp_w[i] || in_ready !== (i == 2 || i == 5)
                || dout_last !== (i == 2 || i == 5))
                $display("FAIL b2b_word%0d: valid=%b dout=%h in_ready=%b last=%b want 1/%h/%b/%b",
                         i, dout_valid, dout, in_ready, dout_last, exp_w[i],
                         (i == 2 || i == 5), (i == 2 || i == 5));
            else passed++;
            tick();
            if (i == 2) in_valid = 1'b0;
        end
        total++;
        if (dout_valid !== 1'b0) $display("FAIL b2b_end: valid=%b want 0", dout_valid);
        else passed++;
    endtask

    task automatic test_idle();
        in_valid = 1'b0; dout_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            dout_ready = i[0];
            #1;
            total++;
            if (dout_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL idle%0d: valid=%b in_ready=%b want 0/1", i, dout_valid, in_ready);
            else passed++;
            tick();
        end
    endtask

    task automatic test_blocked();
        logic [31:0] exp_w [7];
        logic        rdy   [7];
        logic        irdy  [7];
        logic        lst   [7];
        exp_w[0] = 32'h33; exp_w[1] = 32'h32; exp_w[2] = 32'h31; exp_w[3] = 32'h31;
        exp_w[4] = 32'h43; exp_w[5] = 32'h42; exp_w[6] = 32'h41;
        rdy  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        irdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        lst  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        din03 = 32'h33; din02 = 32'h32; din01 = 32'h31; in_valid = 1'b1; dout_ready = 1'b1;
        #1; tick();
        din03 = 32'h43; din02 = 32'h42; din01 = 32'h41;
        for (int i = 0; i < 7; i++) begin
            dout_ready = rdy[i];
            #1;
            total++;
            if (dout_valid !== 1'b1 || dout !== exp_w[i] || in_ready !== irdy[i]
                || dout_last !== lst[i])
                $display("FAIL blocked%0d: valid=%b dout=%h in_ready=%b last=%b want 1/%h/%b/%b",
                         i, dout_valid, dout, in_ready, dout_last, exp_w[i], irdy[i], lst[i]);
            else passed++;
            tick();
            if (i == 3) in_valid = 1'b0;
        end
        dout_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic e_valid;
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            dout_ready = ($urandom_range(0, 3) != 0);
            din03 = $urandom; din02 = $urandom; din01 = $urandom;
            #1;
            e_valid = (mq.size() > 0);
            total++;
            if (dout_valid !== e_valid || dout !== m_shown || in_ready !== m_ready()
                || dout_last !== (mq.size() == 1))
                $display("FAIL rand%0d: valid=%b dout=%h in_ready=%b last=%b want %b/%h/%b/%b",
                         i, dout_valid, dout, in_ready, dout_last, e_valid, m_shown,
                         m_ready(), (mq.size() == 1));
            else passed++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_idle();
        test_blocked();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regs_unload_3.md
REGS_UNLOAD_3 -- requirements
Module: regs_unload_3

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the word width in bits.
REQ-002 The block SHALL have parameter REGDEPTH, default 3, meaning the words per frame; only 3 is supported.
REQ-003 The block SHALL have port clk  input  1  single clock, all state updated on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port din03  input  DATA_WIDTH  oldest word of the frame.
REQ-006 The block SHALL have port din02  input  DATA_WIDTH  middle word of the frame.
REQ-007 The block SHALL have port din01  input  DATA_WIDTH  newest word of the frame.
REQ-008 The block SHALL have port in_valid  input  1  din03..din01 hold a valid frame.
REQ-009 The block SHALL have port in_ready  output  1  block accepts a frame this cycle.
REQ-010 The block SHALL have port dout  output  DATA_WIDTH  serial word out.
REQ-011 The block SHALL have port dout_valid  output  1  dout is valid.
REQ-012 The block SHALL have port dout_ready  input  1  downstream accepts dout this cycle.
REQ-013 The block SHALL have port dout_last  output  1  dout is the final word of the frame.

Function
REQ-014 A frame SHALL be accepted on any rising edge where in_valid and in_ready are both 1; the three words are captured into an internal REGDEPTH-entry buffer.
REQ-015 The FSM SHALL have two states: IDLE (buffer empty) and SEND (buffer holds an unsent or partly sent frame).
REQ-016 The IDLE->SEND transition SHALL occur on frame acceptance; SEND->IDLE SHALL occur when the last word is accepted and no new frame is accepted in the same cycle; SEND->SEND reload SHALL occur when both happen together.
REQ-017 in_ready SHALL be combinational: 1 in IDLE, or in SEND when dout_valid, dout_last and dout_ready are all 1; otherwise 0.
REQ-018 Word order SHALL be din03, then din02, then din01.
REQ-019 dout, dout_valid and dout_last SHALL be registered; the first word SHALL appear exactly one cycle after frame acceptance.
REQ-020 A word SHALL be consumed on any edge where dout_valid and dout_ready are both 1; a 2-bit index SHALL then advance 0->1->2.
REQ-021 While dout_valid is 1 and dout_ready is 0, dout and dout_last SHALL hold stable.
REQ-022 dout_last SHALL be 1 only while index is 2.
REQ-023 With dout_ready held at 1 and in_valid held at 1, frames SHALL stream back to back with no bubble: 3 words per 3 cycles.
REQ-024 dout_valid SHALL be 0 in IDLE; dout SHALL then hold its last value.
REQ-025 in_valid with in_ready at 0 SHALL be ignored; the upstream side holds its frame.

Reset
REQ-026 On rst=1, the block SHALL asynchronously force state=IDLE, index=0, buffer=0, dout=0, dout_valid=0 and dout_last=0.
REQ-027 Reset mid-frame SHALL discard remaining words without emitting them.
REQ-028 in_ready SHALL be 1 from the first edge after rst deasserts.

Structure
REQ-029 DATA_WIDTH, REGDEPTH and the state enum (IDLE, SEND) SHALL live in shared package detdes_pkg.
REQ-030 The block SHALL be a single module with no sub-modules; the index counter and buffer are inline.

Verification
REQ-031 Reset test: assert rst mid-SEND after 1 word -> dout_valid=0 and dout=0 immediately, in_ready=1 on the next edge, and no remaining word is emitted.
REQ-032 Single frame: din03=0xA3, din02=0xA2, din01=0xA1, dout_ready=1 -> dout=0xA3, 0xA2, 0xA1 on cycles +1..+3, and dout_last only with 0xA1.
REQ-033 Backpressure: hold dout_ready=0 for 4 cycles on word 2 -> dout stays 0xA2, dout_valid=1 and in_ready=0 throughout, and the order is preserved.
REQ-034 Back-to-back: two frames (0x13,0x12,0x11) and (0x23,0x22,0x21) -> six consecutive valid words, with in_ready=1 exactly in the cycle 0x11 is accepted.
REQ-035 Idle: in_valid=0 for 10 cycles -> dout_valid=0 and in_ready=1 in every cycle.
REQ-036 Blocked input: in_valid=1 while in SEND and not on the last beat -> the frame is not captured and is taken later, unchanged.
